// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_pkg
// Purpose  : Shared flit field map, flit type encodings, VC FSM state type and
//            the round-robin pick helper for the NoC router input port.
// Revision : 1.0 - initial release
// ============================================================================
package noc_pkg;

    localparam int NUM_VC   = 4;
    localparam int VC_IDX_W = 2;

    localparam logic [1:0] c_FLIT_BODY     = 2'b00;
    localparam logic [1:0] c_FLIT_TAIL     = 2'b01;
    localparam logic [1:0] c_FLIT_HEAD     = 2'b10;
    localparam logic [1:0] c_FLIT_HEADTAIL = 2'b11;

    localparam int c_TYPE_MSB = 15;
    localparam int c_TYPE_LSB = 14;
    localparam int c_DEST_MSB = 11;
    localparam int c_DEST_LSB = 8;
    localparam int c_VC_MSB   = 1;
    localparam int c_VC_LSB   = 0;

    typedef enum logic [1:0] {
        VC_IDLE   = 2'd0,
        VC_ROUTE  = 2'd1,
        VC_ALLOC  = 2'd2,
        VC_ACTIVE = 2'd3
    } vc_state_t;

    function automatic logic is_head(input logic [1:0] ftype);
        return (ftype == c_FLIT_HEAD) || (ftype == c_FLIT_HEADTAIL);
    endfunction

    function automatic logic is_tail(input logic [1:0] ftype);
        return (ftype == c_FLIT_TAIL) || (ftype == c_FLIT_HEADTAIL);
    endfunction

    // Returns {found, index}; the search starts just after the last served VC.
    function automatic logic [VC_IDX_W:0] rr_pick(input logic [NUM_VC-1:0] req,
                                                  input logic [VC_IDX_W-1:0] last);
        logic [VC_IDX_W:0]   res;
        logic [VC_IDX_W-1:0] idx;
        res = '0;
        for (int i = 1; i <= NUM_VC; i++) begin
            idx = last + VC_IDX_W'(i);
            if (!res[VC_IDX_W] && req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/noc_input_port_fifo.sv
`default_nettype none
// ============================================================================
// Module   : vc_fifo
// Purpose  : Per-VC flit FIFO with occupancy count and full/empty flags.
// Revision : 1.0 - initial release
// ============================================================================
module vc_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_DEPTH = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == c_DEPTH);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/noc_input_port.sv
`default_nettype none
// ============================================================================
// Module   : noc_input_port
// Purpose  : 4-VC wormhole router input port: per-VC buffering, on/off flow
//            control, and route / VC / switch request sequencing.
//            Optional macro INPUT_PORT_CHECKS_EN adds simulation checks.
// Revision : 1.0 - initial release
// ============================================================================
module noc_input_port
    import noc_pkg::*;
#(
    parameter int flit_width     = 16,
    parameter int MAX_Packet_NUM = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  VALID,
    input  logic [flit_width-1:0] FLIT_i,
    input  logic                  VC_0_RESERVED,
    input  logic                  VC_1_RESERVED,
    input  logic                  VC_2_RESERVED,
    input  logic                  VC_3_RESERVED,
    input  logic                  VC_ANSWER,
    input  logic                  SW_ANSWER,
    input  logic                  ROUTE_DONE,
    input  logic [3:0]            ROUTE_RESULT,
    output logic                  ON_OFF_0,
    output logic                  ON_OFF_1,
    output logic                  ON_OFF_2,
    output logic                  ON_OFF_3,
    output logic [flit_width-1:0] FLIT_O,
    output logic [3:0]            Route_info,
    output logic                  Start_route,
    output logic [5:0]            Vc_request,
    output logic                  valid_vc_req,
    output logic [3:0]            Sw_request,
    output logic                  Valid_sw_req
);

    localparam int c_CNT_W = $clog2(MAX_Packet_NUM) + 1;
    localparam logic [c_CNT_W-1:0] c_MAX = c_CNT_W'(MAX_Packet_NUM);
    localparam logic [NUM_VC-1:0]  c_ONE = NUM_VC'(1);

    logic [NUM_VC-1:0]     w_reserved;
    logic [NUM_VC-1:0]     w_wr_sel;
    logic [NUM_VC-1:0]     w_push;
    logic [NUM_VC-1:0]     w_pop;
    logic [NUM_VC-1:0]     w_full;
    logic [NUM_VC-1:0]     w_empty;
    logic [NUM_VC-1:0]     w_discard;
    logic [flit_width-1:0] w_front   [NUM_VC];
    logic [c_CNT_W-1:0]    w_count   [NUM_VC];
    logic [c_CNT_W-1:0]    w_cnt_nxt [NUM_VC];

    vc_state_t r_state [NUM_VC];
    vc_state_t w_state_nxt [NUM_VC];
    logic [3:0] r_route_res [NUM_VC];
    logic [NUM_VC-1:0] r_on_off;

    logic                r_route_busy, r_vc_busy, r_sw_busy;
    logic [VC_IDX_W-1:0] r_route_owner, r_vc_owner, r_sw_owner;
    logic [VC_IDX_W-1:0] r_route_last, r_vc_last, r_sw_last;
    logic [3:0]          r_route_info;
    logic [5:0]          r_vc_req;
    logic [3:0]          r_sw_req;
    logic [flit_width-1:0] r_flit_o;

    logic [NUM_VC-1:0]   w_route_elig, w_vc_elig, w_sw_elig;
    logic [VC_IDX_W:0]   w_route_pick, w_vc_pick, w_sw_pick;
    logic [NUM_VC-1:0]   w_route_own, w_vc_own, w_sw_own;
    logic                w_sw_grant;

    assign w_reserved = {VC_3_RESERVED, VC_2_RESERVED, VC_1_RESERVED, VC_0_RESERVED};
    assign w_wr_sel   = c_ONE << FLIT_i[c_VC_MSB:c_VC_LSB];
    assign w_push     = (VALID ? w_wr_sel : '0) & w_reserved & ~w_full;

    assign w_route_own = r_route_busy ? (c_ONE << r_route_owner) : '0;
    assign w_vc_own    = r_vc_busy    ? (c_ONE << r_vc_owner)    : '0;
    assign w_sw_own    = r_sw_busy    ? (c_ONE << r_sw_owner)    : '0;
    assign w_sw_grant  = r_sw_busy && SW_ANSWER && !w_empty[r_sw_owner];
    assign w_pop       = (w_sw_grant ? w_sw_own : '0) | w_discard;

    generate
        for (genvar k = 0; k < NUM_VC; k++) begin : g_vc
            vc_fifo #(
                .WIDTH (flit_width),
                .DEPTH (MAX_Packet_NUM)
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .i_push  (w_push[k]),
                .i_data  (FLIT_i),
                .i_pop   (w_pop[k]),
                .o_data  (w_front[k]),
                .o_count (w_count[k]),
                .o_full  (w_full[k]),
                .o_empty (w_empty[k])
            );
        end
    endgenerate

    always_comb begin
        w_discard = '0;
        for (int k = 0; k < NUM_VC; k++) begin
            w_state_nxt[k]  = r_state[k];
            w_route_elig[k] = (r_state[k] == VC_ROUTE);
            w_vc_elig[k]    = (r_state[k] == VC_ALLOC);
            w_sw_elig[k]    = (r_state[k] == VC_ACTIVE) && !w_empty[k];
            w_cnt_nxt[k]    = w_count[k];
            if (w_push[k] && !w_pop[k]) w_cnt_nxt[k] = w_count[k] + 1'b1;
            if (w_pop[k] && !w_push[k]) w_cnt_nxt[k] = w_count[k] - 1'b1;
            case (r_state[k])
                VC_IDLE: begin
                    if (!w_empty[k] && is_head(w_front[k][c_TYPE_MSB:c_TYPE_LSB])) begin
                        w_state_nxt[k] = VC_ROUTE;
                    end
`ifdef INPUT_PORT_CHECKS_EN
                    // A stray body/tail flit with no packet open is thrown away.
                    if (!w_empty[k] && !is_head(w_front[k][c_TYPE_MSB:c_TYPE_LSB])) begin
                        w_discard[k] = 1'b1;
                    end
`endif
                end
                VC_ROUTE: begin
                    if (w_route_own[k] && ROUTE_DONE) w_state_nxt[k] = VC_ALLOC;
                end
                VC_ALLOC: begin
                    if (w_vc_own[k] && VC_ANSWER) w_state_nxt[k] = VC_ACTIVE;
                end
                VC_ACTIVE: begin
                    if (w_sw_own[k] && w_sw_grant &&
                        is_tail(w_front[k][c_TYPE_MSB:c_TYPE_LSB])) begin
                        w_state_nxt[k] = VC_IDLE;
                    end
                end
                default: w_state_nxt[k] = VC_IDLE;
            endcase
        end
        w_route_pick = rr_pick(w_route_elig, r_route_last);
        w_vc_pick    = rr_pick(w_vc_elig, r_vc_last);
        w_sw_pick    = rr_pick(w_sw_elig, r_sw_last);
    end

    // Each channel is a held level: it re-arbitrates only once its answer lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_VC; k++) begin
                r_state[k]     <= VC_IDLE;
                r_route_res[k] <= '0;
            end
            r_on_off      <= '1;
            r_route_busy  <= 1'b0;
            r_route_owner <= '0;
            r_route_last  <= '0;
            r_route_info  <= '0;
            r_vc_busy     <= 1'b0;
            r_vc_owner    <= '0;
            r_vc_last     <= '0;
            r_vc_req      <= '0;
            r_sw_busy     <= 1'b0;
            r_sw_owner    <= '0;
            r_sw_last     <= '0;
            r_sw_req      <= '0;
            r_flit_o      <= '0;
        end else begin
            for (int k = 0; k < NUM_VC; k++) begin
                r_state[k]  <= w_state_nxt[k];
                r_on_off[k] <= (w_cnt_nxt[k] < c_MAX);
            end

            if (r_route_busy) begin
                if (ROUTE_DONE) begin
                    r_route_busy               <= 1'b0;
                    r_route_last               <= r_route_owner;
                    r_route_res[r_route_owner] <= ROUTE_RESULT;
                end
            end else if (w_route_pick[VC_IDX_W]) begin
                r_route_busy  <= 1'b1;
                r_route_owner <= w_route_pick[VC_IDX_W-1:0];
                r_route_info  <= w_front[w_route_pick[VC_IDX_W-1:0]][c_DEST_MSB:c_DEST_LSB];
            end

            if (r_vc_busy) begin
                if (VC_ANSWER) begin
                    r_vc_busy <= 1'b0;
                    r_vc_last <= r_vc_owner;
                end
            end else if (w_vc_pick[VC_IDX_W]) begin
                r_vc_busy  <= 1'b1;
                r_vc_owner <= w_vc_pick[VC_IDX_W-1:0];
                r_vc_req   <= {r_route_res[w_vc_pick[VC_IDX_W-1:0]], w_vc_pick[VC_IDX_W-1:0]};
            end

            if (r_sw_busy) begin
                if (w_sw_grant) begin
                    r_sw_busy <= 1'b0;
                    r_sw_last <= r_sw_owner;
                    r_flit_o  <= w_front[r_sw_owner];
                end else if (w_empty[r_sw_owner]) begin
                    r_sw_busy <= 1'b0;
                end
            end else if (w_sw_pick[VC_IDX_W]) begin
                r_sw_busy  <= 1'b1;
                r_sw_owner <= w_sw_pick[VC_IDX_W-1:0];
                r_sw_req   <= c_ONE << r_route_res[w_sw_pick[VC_IDX_W-1:0]][3:2];
            end
        end
    end

`ifdef INPUT_PORT_CHECKS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NUM_VC; k++) begin
                if (VALID && w_wr_sel[k] && !w_reserved[k])
                    $error("write to unreserved VC %0d", k);
                if (VALID && w_wr_sel[k] && w_reserved[k] && w_full[k])
                    $error("write to full VC %0d", k);
                if (w_discard[k])
                    $error("body/tail flit at front of idle VC %0d", k);
            end
        end
    end
`endif

    assign ON_OFF_0     = r_on_off[0];
    assign ON_OFF_1     = r_on_off[1];
    assign ON_OFF_2     = r_on_off[2];
    assign ON_OFF_3     = r_on_off[3];
    assign FLIT_O       = r_flit_o;
    assign Route_info   = r_route_info;
    assign Start_route  = r_route_busy;
    assign Vc_request   = r_vc_req;
    assign valid_vc_req = r_vc_busy;
    assign Sw_request   = r_sw_req;
    assign Valid_sw_req = r_sw_busy;

endmodule
`default_nettype wire

// File: tb/tb_noc_input_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_input_port
// Purpose  : Self-checking bench for noc_input_port (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_noc_input_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        VALID = 1'b0;
    logic [15:0] FLIT_i = '0;
    logic [3:0]  r_res = '0;
    logic        VC_ANSWER = 1'b0;
    logic        SW_ANSWER = 1'b0;
    logic        ROUTE_DONE = 1'b0;
    logic [3:0]  ROUTE_RESULT = '0;

    logic        ON_OFF_0, ON_OFF_1, ON_OFF_2, ON_OFF_3;
    logic [15:0] FLIT_O;
    logic [3:0]  Route_info;
    logic        Start_route;
    logic [5:0]  Vc_request;
    logic        valid_vc_req;
    logic [3:0]  Sw_request;
    logic        Valid_sw_req;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_q [$];

    typedef struct {
        logic [1:0]  vc;
        logic [15:0] flit;
        logic [3:0]  rr;
        logic [3:0]  ri;
        logic [5:0]  vr;
        logic [3:0]  sw;
    } vec_t;

    vec_t vecs [4];

    noc_input_port #(
        .flit_width     (16),
        .MAX_Packet_NUM (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .VALID         (VALID),
        .FLIT_i        (FLIT_i),
        .VC_0_RESERVED (r_res[0]),
        .VC_1_RESERVED (r_res[1]),
        .VC_2_RESERVED (r_res[2]),
        .VC_3_RESERVED (r_res[3]),
        .VC_ANSWER     (VC_ANSWER),
        .SW_ANSWER     (SW_ANSWER),
        .ROUTE_DONE    (ROUTE_DONE),
        .ROUTE_RESULT  (ROUTE_RESULT),
        .ON_OFF_0      (ON_OFF_0),
        .ON_OFF_1      (ON_OFF_1),
        .ON_OFF_2      (ON_OFF_2),
        .ON_OFF_3      (ON_OFF_3),
        .FLIT_O        (FLIT_O),
        .Route_info    (Route_info),
        .Start_route   (Start_route),
        .Vc_request    (Vc_request),
        .valid_vc_req  (valid_vc_req),
        .Sw_request    (Sw_request),
        .Valid_sw_req  (Valid_sw_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Every switch grant must emit the oldest outstanding expected flit.
    always @(posedge clk) begin
        if (!rst && Valid_sw_req === 1'b1 && SW_ANSWER === 1'b1) begin
            #1;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL flit_o: unexpected flit %h, expected none", FLIT_O);
            end else begin
                chk("flit_o", 32'(FLIT_O), 32'(exp_q.pop_front()));
            end
        end
    end

    function automatic logic sig(input int sel);
        case (sel)
            0:       return Start_route;
            1:       return valid_vc_req;
            default: return Valid_sw_req;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string name);
        int k = 0;
        while (sig(sel) !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(sig(sel)), 32'd1);
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_flit_o"},     32'(FLIT_O), 0);
        chk({tag, "_route_info"}, 32'(Route_info), 0);
        chk({tag, "_start"},      32'(Start_route), 0);
        chk({tag, "_vc_req"},     32'({valid_vc_req, Vc_request}), 0);
        chk({tag, "_sw_req"},     32'({Valid_sw_req, Sw_request}), 0);
        chk({tag, "_on_off"},     32'({ON_OFF_3, ON_OFF_2, ON_OFF_1, ON_OFF_0}), 32'hF);
    endtask

    // One single-flit packet walked through every handshake stage.
    task automatic run_packet(input vec_t v);
        @(negedge clk);
        r_res  = 4'b0001 << v.vc;
        VALID  = 1'b1;
        FLIT_i = v.flit;
        exp_q.push_back(v.flit);
        @(negedge clk);
        VALID = 1'b0;
        @(negedge clk);
        chk("start_route_early", 32'(Start_route), 0);
        @(negedge clk);
        chk("start_route", 32'(Start_route), 1);
        chk("route_info", 32'(Route_info), 32'(v.ri));
        ROUTE_DONE   = 1'b1;
        ROUTE_RESULT = v.rr;
        @(negedge clk);
        ROUTE_DONE = 1'b0;
        chk("start_route_drop", 32'(Start_route), 0);
        wait_for(1, "valid_vc_req");
        chk("vc_request", 32'(Vc_request), 32'(v.vr));
        VC_ANSWER = 1'b1;
        @(negedge clk);
        VC_ANSWER = 1'b0;
        chk("valid_vc_req_drop", 32'(valid_vc_req), 0);
        wait_for(2, "valid_sw_req");
        chk("sw_request", 32'(Sw_request), 32'(v.sw));
        SW_ANSWER = 1'b1;
        @(negedge clk);
        SW_ANSWER = 1'b0;
        chk("flit_o_direct", 32'(FLIT_O), 32'(v.flit));
        repeat (3) @(negedge clk);
        chk("idle_after_packet", 32'({Start_route, valid_vc_req, Valid_sw_req}), 0);
        r_res = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_start;
        int n_vcreq;
        int k;

        vecs[0] = '{vc: 2'd0, flit: 16'hCA10, rr: 4'b0110, ri: 4'hA, vr: 6'b011000, sw: 4'b0010};
        vecs[1] = '{vc: 2'd1, flit: 16'hC525, rr: 4'b1111, ri: 4'h5, vr: 6'b111101, sw: 4'b1000};
        vecs[2] = '{vc: 2'd2, flit: 16'hC3FE, rr: 4'b0001, ri: 4'h3, vr: 6'b000110, sw: 4'b0001};
        vecs[3] = '{vc: 2'd3, flit: 16'hCF03, rr: 4'b1010, ri: 4'hF, vr: 6'b101011, sw: 4'b0100};

        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");

        for (int i = 0; i < 4; i++) run_packet(vecs[i]);

        // Four VCs back to back with every answer held high.
        @(negedge clk);
        r_res = 4'hF;
        ROUTE_DONE = 1'b1;
        VC_ANSWER = 1'b1;
        SW_ANSWER = 1'b1;
        ROUTE_RESULT = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            VALID  = 1'b1;
            FLIT_i = {12'hCA1, 2'(i), 2'(i)} + 16'h0010 * 16'(i);
            exp_q.push_back(FLIT_i);
            @(negedge clk);
        end
        VALID = 1'b0;
        drain("four_vc_drain", 120);
        ROUTE_DONE = 1'b0;
        VC_ANSWER = 1'b0;
        SW_ANSWER = 1'b0;
        r_res = '0;
        repeat (3) @(negedge clk);

        // Fill VC2 to capacity, then try one more write.
        r_res = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            if (i == 7) chk("on_off2_at_7", 32'(ON_OFF_2), 1);
            if (i == 8) chk("on_off2_full", 32'(ON_OFF_2), 0);
            if (i < 9) begin
                VALID  = 1'b1;
                FLIT_i = (i == 8) ? 16'hCBFE : {4'hC, 4'hB, 6'(i), 2'b10};
                if (i < 8) exp_q.push_back(FLIT_i);
            end else begin
                VALID = 1'b0;
            end
            @(negedge clk);
        end
        chk("on_off2_after_drop", 32'(ON_OFF_2), 0);
        ROUTE_DONE = 1'b1;
        VC_ANSWER = 1'b1;
        wait_for(2, "fc_valid_sw_req");
        SW_ANSWER = 1'b1;
        @(negedge clk);
        SW_ANSWER = 1'b0;
        chk("on_off2_after_pop", 32'(ON_OFF_2), 1);
        SW_ANSWER = 1'b1;
        drain("fc_drain", 250);
        ROUTE_DONE = 1'b0;
        VC_ANSWER = 1'b0;
        SW_ANSWER = 1'b0;
        repeat (8) @(negedge clk);
        chk("fc_no_extra_req", 32'({Start_route, Valid_sw_req}), 0);
        r_res = '0;

        // Write to VC1 without its reservation.
        r_res  = 4'b1101;
        VALID  = 1'b1;
        FLIT_i = 16'hCA29;
        @(negedge clk);
        VALID = 1'b0;
        repeat (4) @(negedge clk);
        chk("unreserved_no_route", 32'(Start_route), 0);
        chk("unreserved_on_off1", 32'(ON_OFF_1), 1);
        r_res = '0;

        // Three-flit packet on VC1: one route and one VC request only.
        r_res = 4'b0010;
        ROUTE_DONE = 1'b1;
        VC_ANSWER = 1'b1;
        SW_ANSWER = 1'b1;
        ROUTE_RESULT = 4'b1000;
        n_start = 0;
        n_vcreq = 0;
        VALID = 1'b1;
        FLIT_i = 16'h8A01;
        exp_q.push_back(FLIT_i);
        @(negedge clk);
        FLIT_i = 16'h0001;
        exp_q.push_back(FLIT_i);
        @(negedge clk);
        FLIT_i = 16'h4001;
        exp_q.push_back(FLIT_i);
        @(negedge clk);
        VALID = 1'b0;
        k = 0;
        while ((exp_q.size() != 0 || k < 40) && k < 80) begin
            if (Start_route === 1'b1) n_start++;
            if (valid_vc_req === 1'b1) n_vcreq++;
            @(negedge clk);
            k++;
        end
        chk("multi_drain", exp_q.size(), 0);
        exp_q.delete();
        chk("multi_route_reqs", n_start, 1);
        chk("multi_vc_reqs", n_vcreq, 1);
        chk("multi_idle", 32'(Valid_sw_req), 0);
        ROUTE_DONE = 1'b0;
        VC_ANSWER = 1'b0;
        SW_ANSWER = 1'b0;

        // Reset in the middle of a packet discards everything.
        ROUTE_DONE = 1'b1;
        VC_ANSWER = 1'b1;
        VALID = 1'b1;
        FLIT_i = 16'h8A01;
        @(negedge clk);
        FLIT_i = 16'h0001;
        @(negedge clk);
        VALID = 1'b0;
        wait_for(2, "mid_valid_sw_req");
        ROUTE_DONE = 1'b0;
        VC_ANSWER = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        r_res = '0;
        check_reset_outputs("mid_reset");
        run_packet(vecs[1]);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
